// File: rtl/draw_blocks.sv
// draw_blocks: block-wall layer renderer and block state keeper.
//
// Renders the block wall as a 4-bit layer word {present, rgb} two cycles
// after the pixel coordinate is presented, holds one alive bit per block,
// and services single-cycle hit requests from the collision logic.
//
// Ports:
//   clock          pixel clock
//   reset          synchronous, active-high
//   visible        pixel is in the active area
//   px, py         pixel coordinate (10 bits each)
//   init           level; restores every block while high
//   hit_valid      single-cycle hit request
//   hit_row/col    target block of the hit
//   hit_ack        one-cycle pulse the cycle after hit_valid
//   hit_was_alive  prior state of the hit block, valid with hit_ack
//   out_block      [3] present, [2:0] rgb
//   blocks_left    number of alive blocks
//   all_clear      high while blocks_left == 0
//
// Build option: define DRAW_BLOCKS_ARMOR_EN to give every row-0 block one
// armor bit that absorbs the first hit and renders the block white.

module draw_blocks #(
   parameter int ROWS  = 6,
   parameter int COLS  = 10,
   parameter int BLK_W = 64,
   parameter int BLK_H = 16,
   parameter int TOP   = 32
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       visible,
   input  logic [9:0] px,
   input  logic [9:0] py,
   input  logic       init,
   input  logic       hit_valid,
   input  logic [2:0] hit_row,
   input  logic [3:0] hit_col,
   output logic       hit_ack,
   output logic       hit_was_alive,
   output logic [3:0] out_block,
   output logic [6:0] blocks_left,
   output logic       all_clear
);

   localparam int N  = ROWS * COLS;
   localparam int LW = $clog2(BLK_W);
   localparam int LH = $clog2(BLK_H);

   localparam logic [10:0]  X_END      = 11'(COLS * BLK_W);
   localparam logic [10:0]  Y_TOP      = 11'(TOP);
   localparam logic [10:0]  Y_END      = 11'(TOP + ROWS * BLK_H);
   localparam logic [6:0]   N7         = 7'(N);
   // Alive vector is padded to 128 entries so a 7-bit index never runs off
   // the end; the pad bits are never set.
   localparam logic [127:0] ALL_ALIVE  = {{(128 - N){1'b0}}, {N{1'b1}}};
   localparam logic [15:0]  ALL_ARMOR  = {{(16 - COLS){1'b0}}, {COLS{1'b1}}};

   logic [127:0] alive, alive_nx;
   logic [15:0]  armor, armor_nx;
   logic [6:0]   left_nx;
   logic         ack_nx, was_nx;

   // ---------------- render stage 1 ----------------
   logic [9:0] dy;
   logic       in_wall_c, gap_c;
   logic [3:0] col_c;
   logic [2:0] row_c;

   logic       s1_in_wall, s1_gap;
   logic [3:0] s1_col;
   logic [2:0] s1_row;

   always_comb begin
      dy        = py - 10'(TOP);
      in_wall_c = visible && ({1'b0, px} < X_END) &&
                  ({1'b0, py} >= Y_TOP) && ({1'b0, py} < Y_END);
      gap_c     = (&px[LW-1:0]) || (&dy[LH-1:0]);
      col_c     = 4'(px >> LW);
      row_c     = 3'(dy >> LH);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         s1_in_wall <= 1'b0;
         s1_gap     <= 1'b0;
         s1_col     <= '0;
         s1_row     <= '0;
      end else begin
         s1_in_wall <= in_wall_c;
         s1_gap     <= gap_c;
         s1_col     <= col_c;
         s1_row     <= row_c;
      end
   end

   // ---------------- render stage 2 ----------------
   logic [6:0] pix_idx;
   logic [2:0] rgb;
   logic       pix_on;
   logic [3:0] blk_c;

   always_comb begin
      pix_idx = 7'(32'(s1_row) * COLS + 32'(s1_col));
      rgb     = (s1_row == 3'd7) ? 3'd1 : s1_row + 3'd1;
      pix_on  = s1_in_wall && !s1_gap && alive[pix_idx];
      blk_c   = pix_on ? {1'b1, rgb} : 4'b0000;
`ifdef DRAW_BLOCKS_ARMOR_EN
      if (pix_on && (s1_row == 3'd0) && armor[s1_col])
         blk_c = 4'b1111;
`endif
   end

   // ---------------- hit handling ----------------
   logic [6:0] hit_idx;
   logic       in_range, armored;

   always_comb begin
      hit_idx  = 7'(32'(hit_row) * COLS + 32'(hit_col));
      in_range = (32'(hit_row) < ROWS) && (32'(hit_col) < COLS);
      armored  = 1'b0;
`ifdef DRAW_BLOCKS_ARMOR_EN
      armored  = (hit_row == 3'd0) && armor[hit_col];
`endif
      alive_nx = alive;
      armor_nx = armor;
      left_nx  = blocks_left;
      ack_nx   = hit_valid;
      was_nx   = 1'b0;
      // init outranks a simultaneous hit: the hit is still acknowledged but
      // reports a dead block and changes nothing.
      if (init) begin
         alive_nx = ALL_ALIVE;
         armor_nx = ALL_ARMOR;
         left_nx  = N7;
      end else if (hit_valid && in_range) begin
         if (armored) begin
            armor_nx[hit_col] = 1'b0;
            was_nx            = 1'b1;
         end else begin
            was_nx            = alive[hit_idx];
            alive_nx[hit_idx] = 1'b0;
            if (alive[hit_idx] && (blocks_left != 7'd0))
               left_nx = blocks_left - 7'd1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         alive         <= ALL_ALIVE;
         armor         <= ALL_ARMOR;
         blocks_left   <= N7;
         all_clear     <= 1'b0;
         hit_ack       <= 1'b0;
         hit_was_alive <= 1'b0;
         out_block     <= 4'b0000;
      end else begin
         alive         <= alive_nx;
         armor         <= armor_nx;
         blocks_left   <= left_nx;
         all_clear     <= (left_nx == 7'd0);
         hit_ack       <= ack_nx;
         hit_was_alive <= was_nx;
         out_block     <= blk_c;
      end
   end

endmodule

// File: tb/tb_draw_blocks.sv
// tb_draw_blocks: self-checking bench for draw_blocks with a behavioural
// model of the wall (per-block alive array, pixel arithmetic) and a mix of
// directed and $urandom stimulus.

module tb_draw_blocks;

   localparam int ROWS = 6, COLS = 10, BW = 64, BH = 16, TOPY = 32;
   localparam int NB = ROWS * COLS;

   logic       clock = 1'b0;
   logic       reset, visible, init, hit_valid;
   logic [9:0] px, py;
   logic [2:0] hit_row;
   logic [3:0] hit_col;
   logic       hit_ack, hit_was_alive, all_clear;
   logic [3:0] out_block;
   logic [6:0] blocks_left;

   int passed = 0;
   int total  = 0;

   bit m_alive [NB];
   bit m_armor [COLS];

   draw_blocks #(.ROWS(ROWS), .COLS(COLS), .BLK_W(BW), .BLK_H(BH), .TOP(TOPY)) dut (
      .clock(clock), .reset(reset), .visible(visible), .px(px), .py(py),
      .init(init), .hit_valid(hit_valid), .hit_row(hit_row), .hit_col(hit_col),
      .hit_ack(hit_ack), .hit_was_alive(hit_was_alive), .out_block(out_block),
      .blocks_left(blocks_left), .all_clear(all_clear)
   );

   always #5 clock = ~clock;

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic void model_restore();
      for (int i = 0; i < NB; i++) m_alive[i] = 1'b1;
`ifdef DRAW_BLOCKS_ARMOR_EN
      for (int i = 0; i < COLS; i++) m_armor[i] = 1'b1;
`else
      for (int i = 0; i < COLS; i++) m_armor[i] = 1'b0;
`endif
   endfunction

   function automatic int model_left();
      int n = 0;
      for (int i = 0; i < NB; i++) n += int'(m_alive[i]);
      return n;
   endfunction

   function automatic logic [3:0] model_pix(input int x, input int y, input bit vis);
      int r, c;
      if (!vis || x >= COLS * BW || y < TOPY || y >= TOPY + ROWS * BH) return 4'b0000;
      c = x / BW;
      r = (y - TOPY) / BH;
      if ((x % BW) == BW - 1 || ((y - TOPY) % BH) == BH - 1) return 4'b0000;
      if (!m_alive[r * COLS + c]) return 4'b0000;
      if (r == 0 && m_armor[c]) return 4'b1111;
      return {1'b1, 3'((r % 7) + 1)};
   endfunction

   // Present one hit (optionally with init), update the model, check results.
   task automatic do_hit(input int r, input int c, input bit with_init, input string tag);
      bit exp_was;
      hit_row   = 3'(r);
      hit_col   = 4'(c);
      hit_valid = 1'b1;
      init      = with_init;
      exp_was   = 1'b0;
      if (with_init) begin
         model_restore();
      end else if (r < ROWS && c < COLS) begin
         if (r == 0 && m_armor[c]) begin
            m_armor[c] = 1'b0;
            exp_was    = 1'b1;
         end else begin
            exp_was            = m_alive[r * COLS + c];
            m_alive[r * COLS + c] = 1'b0;
         end
      end
      tick;
      hit_valid = 1'b0;
      init      = 1'b0;
      check({tag, "_ack"}, 32'(hit_ack), 32'd1);
      check({tag, "_was"}, 32'(hit_was_alive), 32'(exp_was));
      check({tag, "_left"}, 32'(blocks_left), 32'(model_left()));
      check({tag, "_clear"}, 32'(all_clear), 32'(model_left() == 0));
   endtask

   task automatic pix_check(input int x, input int y, input bit vis, input string tag);
      px      = 10'(x);
      py      = 10'(y);
      visible = vis;
      tick;
      tick;
      check(tag, 32'(out_block), 32'(model_pix(x, y, vis)));
   endtask

   initial begin
      int op, r, c;
      reset = 1'b1; visible = 1'b1; init = 1'b0; hit_valid = 1'b0;
      px = 10'd70; py = 10'd50; hit_row = '0; hit_col = '0;
      model_restore();
      tick;
      tick;
      check("rst_out_block", 32'(out_block), 32'd0);
      check("rst_hit_ack", 32'(hit_ack), 32'd0);
      check("rst_was_alive", 32'(hit_was_alive), 32'd0);
      check("rst_blocks_left", 32'(blocks_left), 32'd60);
      check("rst_all_clear", 32'(all_clear), 32'd0);
      reset = 1'b0;

      // Directed rendering.
      pix_check(70, 50, 1'b1, "pix_70_50");
      check("pix_70_50_const", 32'(out_block), 32'b1010);
      pix_check(127, 50, 1'b1, "pix_col_gap");
      pix_check(700, 50, 1'b1, "pix_right_of_wall");
      pix_check(70, 50, 1'b0, "pix_invisible");
      pix_check(10, 47, 1'b1, "pix_row_gap");
      pix_check(10, 31, 1'b1, "pix_above_wall");
      pix_check(10, 128, 1'b1, "pix_below_wall");
      pix_check(10, 126, 1'b1, "pix_row5");
      pix_check(639, 40, 1'b1, "pix_last_col_gap");
      pix_check(638, 40, 1'b1, "pix_last_col");
      pix_check(0, 32, 1'b1, "pix_origin");

      // Hit (1,1) while pixel (70,50) is on screen; it must vanish next cycle.
      px = 10'd70; py = 10'd50; visible = 1'b1;
      tick;
      tick;
      do_hit(1, 1, 1'b0, "hit_1_1");
      check("hit_1_1_left_const", 32'(blocks_left), 32'd59);
      tick;
      check("hit_1_1_vanish", 32'(out_block), 32'd0);
      check("ack_single_pulse", 32'(hit_ack), 32'd0);
      do_hit(1, 1, 1'b0, "hit_1_1_again");
      do_hit(7, 2, 1'b0, "hit_row_oob");
      do_hit(2, 12, 1'b0, "hit_col_oob");
      do_hit(0, 0, 1'b1, "init_and_hit");
      check("init_left_const", 32'(blocks_left), 32'd60);
      pix_check(10, 40, 1'b1, "pix_0_0_after_init");

`ifdef DRAW_BLOCKS_ARMOR_EN
      check("armor_pix_const", 32'(out_block), 32'b1111);
      do_hit(0, 0, 1'b0, "armor_hit1");
      check("armor_left_const", 32'(blocks_left), 32'd60);
      pix_check(10, 40, 1'b1, "armor_pix_after1");
      check("armor_pix_after1_const", 32'(out_block), 32'b1001);
      do_hit(0, 0, 1'b0, "armor_hit2");
      pix_check(10, 40, 1'b1, "armor_pix_after2");
      do_hit(0, 0, 1'b1, "armor_restore");
`else
      check("row0_pix_const", 32'(out_block), 32'b1001);
`endif

      // Randomized mix of hits, init+hit and pixel probes.
      for (int it = 0; it < 400; it++) begin
         op = int'($urandom_range(0, 9));
         r  = int'($urandom_range(0, 7));
         c  = int'($urandom_range(0, 11));
         if (op <= 4) begin
            do_hit(r, c, 1'b0, "rnd_hit");
         end else if (op == 5) begin
            if ($urandom_range(0, 3) == 0) do_hit(r, c, 1'b1, "rnd_init_hit");
            else do_hit(r, c, 1'b0, "rnd_hit2");
         end else begin
            pix_check(int'($urandom_range(0, 700)), int'($urandom_range(0, 150)),
                      ($urandom_range(0, 7) != 0), "rnd_pix");
         end
      end

      // Clear the whole wall back-to-back.
      do_hit(0, 0, 1'b1, "clear_init");
      for (int rr = 0; rr < ROWS; rr++)
         for (int cc = 0; cc < COLS; cc++)
            for (int k = 0; k < 2 && m_alive[rr * COLS + cc]; k++)
               do_hit(rr, cc, 1'b0, "clear_hit");
      check("clear_left_zero", 32'(blocks_left), 32'd0);
      check("clear_all_clear", 32'(all_clear), 32'd1);
      do_hit(3, 4, 1'b0, "hit_after_clear");
      check("after_clear_left_zero", 32'(blocks_left), 32'd0);
      pix_check(70, 50, 1'b1, "pix_cleared");

      // Mid-frame reset restores the wall and clears the pipeline.
      px = 10'd70; py = 10'd50; visible = 1'b1;
      reset = 1'b1;
      tick;
      check("midrst_out_block", 32'(out_block), 32'd0);
      check("midrst_left", 32'(blocks_left), 32'd60);
      check("midrst_all_clear", 32'(all_clear), 32'd0);
      reset = 1'b0;
      model_restore();
      tick;
      tick;
      check("midrst_resume", 32'(out_block), 32'b1010);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
